// File: rtl/qa_drv_rd_arbiter_pkg.sv
// Shared CCI read-driver definitions: header field layout, read request
// type code and the read-header builder used by the arbiter.
package qa_driver_types;

  localparam int TX_HDR_W    = 61;
  localparam int HDR_TYPE_LO = 52;
  localparam int HDR_TYPE_W  = 4;
  localparam int HDR_ADDR_LO = 14;
  localparam int HDR_ADDR_W  = 32;
  localparam int HDR_SEL_BIT = 12;
  localparam int HDR_TAG_LO  = 0;
  localparam int HDR_TAG_W   = 12;

  localparam logic [HDR_TYPE_W-1:0] RD_REQ_TYPE = 4'h4;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_sel_e;

  // Read request header; every bit outside the named fields stays zero.
  function automatic logic [TX_HDR_W-1:0] build_rd_hdr(
    input logic [HDR_ADDR_W-1:0] addr,
    input logic                  sel,
    input logic [HDR_TAG_W-1:0]  tag
  );
    logic [TX_HDR_W-1:0] h;
    h = '0;
    h[HDR_TYPE_LO +: HDR_TYPE_W] = RD_REQ_TYPE;
    h[HDR_ADDR_LO +: HDR_ADDR_W] = addr;
    h[HDR_SEL_BIT]               = sel;
    h[HDR_TAG_LO +: HDR_TAG_W]   = tag;
    return h;
  endfunction

endpackage

// File: rtl/qa_drv_credit_counter.sv
// Per-requester outstanding-read counter. Saturates at zero on a stray
// response and flags it so the top can latch an error.
module qa_drv_credit_counter #(
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic underflow
);

  logic [5:0] count;

  // Simultaneous issue and return cancel; a return at zero is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 6'd1;
    end else if (!inc && dec && count != 6'd0) begin
      count <= count - 6'd1;
    end
  end

  assign avail     = count < 6'(MAX_OUTSTANDING);
  assign underflow = dec && (count == 6'd0);

endmodule

// File: rtl/qa_drv_rd_arbiter.sv
// Two-requester CCI channel-0 read arbiter: round-robin grant with
// per-requester credit limits, registered request issue and registered
// response routing on the requester-select header bit.
module qa_drv_rd_arbiter
  import qa_driver_types::*;
#(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_TAG_WIDTH    = 13,
  parameter int MAX_OUTSTANDING  = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          req_valid,
  input  logic [1:0][31:0]                    req_addr,
  input  logic [1:0][CCI_TAG_WIDTH-2:0]       req_tag,
  output logic [1:0]                          req_ready,
  output logic [CCI_TX_HDR_WIDTH-1:0]         C0TxHdr,
  output logic                                C0TxRdValid,
  input  logic                                C0TxAlmFull,
  input  logic [CCI_RX_HDR_WIDTH-1:0]         C0RxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]           C0RxData,
  input  logic                                C0RxRdValid,
  output logic [1:0]                          rsp_valid,
  output logic [CCI_TAG_WIDTH-2:0]            rsp_tag,
  output logic [CCI_DATA_WIDTH-1:0]           rsp_data,
  output logic                                err_underflow
);

  logic [1:0] avail;
  logic [1:0] underflow;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] acc;
  logic [1:0] rsp_hit;
  logic       rx_sel;
  logic       acc_sel;
  req_sel_e   last_grant;

  assign eligible = req_valid & avail & {2{~C0TxAlmFull}};

  // Round-robin: the requester that did not win last time looks first.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (last_grant == REQ_1) begin
        if (eligible[0])      grant = 2'b01;
        else if (eligible[1]) grant = 2'b10;
      end else begin
        if (eligible[1])      grant = 2'b10;
        else if (eligible[0]) grant = 2'b01;
      end
    end
  end

  assign req_ready = grant;
  assign acc       = req_valid & req_ready;
  assign acc_sel   = acc[1];

  assign rx_sel  = C0RxHdr[CCI_TAG_WIDTH-1];
  assign rsp_hit = {C0RxRdValid & rx_sel, C0RxRdValid & ~rx_sel};

  for (genvar g = 0; g < 2; g++) begin : g_cred
    qa_drv_credit_counter #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cred (
      .clk      (clk),
      .reset    (reset),
      .inc      (acc[g]),
      .dec      (rsp_hit[g]),
      .avail    (avail[g]),
      .underflow(underflow[g])
    );
  end

  // Issue stage: register the accepted request and remember the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      C0TxRdValid <= 1'b0;
      C0TxHdr     <= '0;
      last_grant  <= REQ_1;
    end else begin
      C0TxRdValid <= |acc;
      if (|acc) begin
        C0TxHdr    <= CCI_TX_HDR_WIDTH'(build_rd_hdr(req_addr[acc_sel], acc_sel,
                                                     HDR_TAG_W'(req_tag[acc_sel])));
        last_grant <= req_sel_e'(acc_sel);
      end
    end
  end

  // Response stage: route to the requester named in the header, and latch
  // any response that arrives with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid     <= 2'b00;
      rsp_tag       <= '0;
      rsp_data      <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp_valid     <= rsp_hit;
      err_underflow <= err_underflow | (|underflow);
      if (C0RxRdValid) begin
        rsp_tag  <= C0RxHdr[CCI_TAG_WIDTH-2:0];
        rsp_data <= C0RxData;
      end
    end
  end

endmodule

// File: doc/qa_drv_rd_arbiter.md
QA_DRV_RD_ARBITER -- requirements
Module: qa_drv_rd_arbiter

Interface
REQ-001 Parameter CCI_DATA_WIDTH, default 512: read-response data width.
REQ-002 Parameter CCI_RX_HDR_WIDTH, default 18: RX header width.
REQ-003 Parameter CCI_TX_HDR_WIDTH, default 61: TX header width.
REQ-004 Parameter CCI_TAG_WIDTH, default 13: mdata width; bit CCI_TAG_WIDTH-1 is the requester select.
REQ-005 Parameter MAX_OUTSTANDING, default 32: per-requester outstanding-read limit, range 1..63.
REQ-006 Port clk, in, 1: single clock. There is one clock; all logic is on its rising edge.
REQ-007 Port reset, in, 1: reset is synchronous and active-high.
REQ-008 Port req_valid[1:0], in, 2: requester i presents a read.
REQ-009 Port req_addr[1:0], in, 2x32: cache-line address per requester.
REQ-010 Port req_tag[1:0], in, 2x(CCI_TAG_WIDTH-1): requester mdata.
REQ-011 Port req_ready[1:0], out, 2: request accepted this cycle.
REQ-012 Port C0TxHdr, out, CCI_TX_HDR_WIDTH: read request header.
REQ-013 Port C0TxRdValid, out, 1: read request valid.
REQ-014 Port C0TxAlmFull, in, 1: channel-0 back-pressure.
REQ-015 Port C0RxHdr, in, CCI_RX_HDR_WIDTH; C0RxData, in, CCI_DATA_WIDTH; C0RxRdValid, in, 1: read responses.
REQ-016 Port rsp_valid[1:0], out, 2; rsp_tag, out, CCI_TAG_WIDTH-1; rsp_data, out, CCI_DATA_WIDTH: routed responses.
REQ-017 Port err_underflow, out, 1: sticky response-without-outstanding flag.

Function
REQ-018 Grant is issued only when req_valid[i] is high, C0TxAlmFull is low and outstanding[i] < MAX_OUTSTANDING.
REQ-019 req_ready[i] is combinational, high for at most one i per cycle; acceptance is req_valid[i] && req_ready[i].
REQ-020 Round-robin between eligible requesters; last_grant flips only on acceptance; after reset requester 0 has priority.
REQ-021 Accepted request appears on C0TxRdValid/C0TxHdr exactly 1 cycle later (registered); C0TxRdValid is low in any cycle following no acceptance.
REQ-022 Header: [55:52]=4'h4, [45:14]=req_addr, [12]=i, [11:0]=req_tag, all other bits 0.
REQ-023 On C0RxRdValid, C0RxHdr[12] selects i; rsp_valid[i], rsp_tag=C0RxHdr[11:0] and rsp_data=C0RxData are registered, latency 1.
REQ-024 outstanding[i] (6 bits) increments on acceptance, decrements on routed response; both same cycle leaves it unchanged.
REQ-025 A response with outstanding[i]==0 leaves the counter at 0 and sets err_underflow until reset.
REQ-026 C0TxAlmFull is sampled in the grant cycle; a request accepted one cycle before assertion is still issued.

Reset
REQ-027 While reset is high: req_ready=0, C0TxRdValid=0, C0TxHdr=0, rsp_valid=0, rsp_tag=0, rsp_data=0, err_underflow=0, outstanding[*]=0, last_grant=1.
REQ-028 Reset asserted mid-operation discards in-flight pipeline stages; responses arriving after reset deassertion follow REQ-025.

Structure
REQ-029 Header field offsets, request-type code 4'h4 and the header-build function belong in the shared qa_driver_types package.
REQ-030 The per-requester credit counter is one sub-module, qa_drv_credit_counter, instantiated twice.

Verification
REQ-031 Both requesters valid continuously, AlmFull=0 -> grants alternate 0,1,0,1; C0TxRdValid high every cycle from cycle 2.
REQ-032 Requester 0 alone issues 32 reads with no responses -> req_ready[0] low on the 33rd; one response restores it next cycle.
REQ-033 AlmFull=1 for 10 cycles with both valid -> no acceptance in those cycles; at most one request issued after assertion.
REQ-034 Response with C0RxHdr[12]=1, [11:0]=12'hABC -> rsp_valid[1]=1, rsp_tag=12'hABC one cycle later; rsp_valid[0]=0.
REQ-035 Response for requester 1 with outstanding[1]==0 -> err_underflow=1, counter remains 0, stays set until reset.
REQ-036 Acceptance and response for requester 0 in the same cycle at outstanding=5 -> outstanding stays 5.
